// File: rtl/ysyx_25040105_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding
// and the RV32I funct3 encodings for loads and stores.
package ysyx_25040105_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/ysyx_25040105_lsu_align.sv
// Byte-lane logic for the LSU: store strobe/data shifting, access legality
// and misalignment detection on the incoming op, and load-word extraction
// with sign/zero extension on the captured op.
module ysyx_25040105_lsu_align
    import ysyx_25040105_pkg::*;
(
    // request side (live inputs, evaluated at accept)
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic        ren_i,
    input  logic        wen_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic        err_o,
    // response side (captured op, evaluated when the load word returns)
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic        illegal;
    logic        misalign;
    logic [3:0]  base_mask;
    logic [31:0] rshift;

    // Legality: funct3 must be one the op supports, and load+store at once is meaningless
    always_comb begin
        illegal = 1'b0;
        if (ren_i && wen_i) begin
            illegal = 1'b1;
        end else if (ren_i) begin
            case (funct3_i)
                LB, LH, LW, LBU, LHU: illegal = 1'b0;
                default:              illegal = 1'b1;
            endcase
        end else if (wen_i) begin
            case (funct3_i)
                SB, SH, SW: illegal = 1'b0;
                default:    illegal = 1'b1;
            endcase
        end
    end

    // Natural alignment: halfwords on even bytes, words on word boundaries
    always_comb begin
        misalign = 1'b0;
        if (ren_i || wen_i) begin
            if (funct3_i[1:0] == 2'b01)
                misalign = addr_lo_i[0];
            else if (funct3_i[1:0] == 2'b10)
                misalign = (addr_lo_i != 2'b00);
        end
        err_o = illegal | misalign;
    end

    // Store lanes: size-based strobe and data both shifted to the addressed byte
    always_comb begin
        case (funct3_i[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        wmask_o = base_mask << addr_lo_i;
        wdata_o = wdata_i << {addr_lo_i, 3'b000};
    end

    // Load lanes: bring the addressed byte/halfword to bit 0, then extend
    always_comb begin
        rshift = rdata_i >> {ld_addr_lo_i, 3'b000};
        case (ld_funct3_i)
            LB:      ld_data_o = {{24{rshift[7]}}, rshift[7:0]};
            LH:      ld_data_o = {{16{rshift[15]}}, rshift[15:0]};
            LBU:     ld_data_o = {24'd0, rshift[7:0]};
            LHU:     ld_data_o = {16'd0, rshift[15:0]};
            default: ld_data_o = rshift;
        endcase
    end

endmodule

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit: accepts one EXU result at a time, issues at most one
// memory request, and hands a registered write-back beat to the WBU.
// Non-memory ops and illegal/misaligned ops bypass memory entirely.
module ysyx_25040105_lsu
    import ysyx_25040105_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // EXU side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_wen,
    // memory side
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    // WBU side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_wen,
    output logic        out_err
);

    lsu_state_e  state_q;
    logic        in_ready_q;
    logic        mem_req_valid_q;
    logic        mem_req_wen_q;
    logic [31:0] mem_req_addr_q;
    logic [31:0] mem_req_wdata_q;
    logic [3:0]  mem_req_wmask_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [4:0]  out_rd_q;
    logic        out_reg_wen_q;
    logic        out_err_q;
    // captured op fields needed after accept
    logic        is_load_q;
    logic [1:0]  ld_lo_q;
    logic [2:0]  ld_f3_q;

    logic [3:0]  al_wmask;
    logic [31:0] al_wdata;
    logic        al_err;
    logic [31:0] al_ld_data;

    ysyx_25040105_lsu_align u_align (
        .addr_lo_i    (in_addr[1:0]),
        .wdata_i      (in_wdata),
        .funct3_i     (in_funct3),
        .ren_i        (in_ren),
        .wen_i        (in_wen),
        .wmask_o      (al_wmask),
        .wdata_o      (al_wdata),
        .err_o        (al_err),
        .ld_addr_lo_i (ld_lo_q),
        .ld_funct3_i  (ld_f3_q),
        .rdata_i      (mem_resp_rdata),
        .ld_data_o    (al_ld_data)
    );

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            in_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_wen_q   <= 1'b0;
            mem_req_addr_q  <= 32'd0;
            mem_req_wdata_q <= 32'd0;
            mem_req_wmask_q <= 4'd0;
            out_valid_q     <= 1'b0;
            out_data_q      <= 32'd0;
            out_rd_q        <= 5'd0;
            out_reg_wen_q   <= 1'b0;
            out_err_q       <= 1'b0;
            is_load_q       <= 1'b0;
            ld_lo_q         <= 2'd0;
            ld_f3_q         <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        out_rd_q   <= in_rd;
                        is_load_q  <= in_ren;
                        ld_lo_q    <= in_addr[1:0];
                        ld_f3_q    <= in_funct3;
                        if (al_err) begin
                            // faulting op: report without touching memory
                            out_err_q     <= 1'b1;
                            out_reg_wen_q <= 1'b0;
                            out_data_q    <= 32'd0;
                            out_valid_q   <= 1'b1;
                            state_q       <= DONE;
                        end else if (!in_ren && !in_wen) begin
                            // ALU result passes straight to write-back
                            out_err_q     <= 1'b0;
                            out_reg_wen_q <= in_reg_wen;
                            out_data_q    <= in_addr;
                            out_valid_q   <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            out_err_q       <= 1'b0;
                            out_reg_wen_q   <= in_ren ? in_reg_wen : 1'b0;
                            out_data_q      <= 32'd0;
                            mem_req_valid_q <= 1'b1;
                            mem_req_wen_q   <= in_wen;
                            mem_req_addr_q  <= {in_addr[31:2], 2'b00};
                            mem_req_wdata_q <= in_wen ? al_wdata : 32'd0;
                            mem_req_wmask_q <= in_wen ? al_wmask : 4'd0;
                            state_q         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (is_load_q)
                            out_data_q <= al_ld_data;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_wen   = mem_req_wen_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign mem_req_wmask = mem_req_wmask_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_rd        = out_rd_q;
    assign out_reg_wen   = out_reg_wen_q;
    assign out_err       = out_err_q;

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Directed bench for the LSU with a write-back scoreboard and a
// hand-driven memory responder.
module tb_ysyx_25040105_lsu;
    import ysyx_25040105_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_ren;
    logic        in_wen;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_reg_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_reg_wen;
    logic        out_err;

    always #5 clk = ~clk;

    ysyx_25040105_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_ren         (in_ren),
        .in_wen         (in_wen),
        .in_funct3      (in_funct3),
        .in_rd          (in_rd),
        .in_reg_wen     (in_reg_wen),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_rd         (out_rd),
        .out_reg_wen    (out_reg_wen),
        .out_err        (out_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        reg_wen;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic chk_data,
                            input logic [4:0] rd, input logic reg_wen, input logic err);
        exp_t e;
        e.data = data; e.chk_data = chk_data; e.rd = rd; e.reg_wen = reg_wen; e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic rwen);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; in_rd = rd; in_reg_wen = rwen;
        tick();
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0;
        in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0; in_reg_wen = 1'b0;
    endtask

    // Wait for a request, check its fields across `hold` stalled cycles, accept it,
    // then return one response beat on the following cycle.
    task automatic serve_mem(input logic [31:0] exp_addr, input logic exp_wen,
                             input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                             input logic [31:0] rdata, input int hold);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        for (int i = 0; i <= hold; i++) begin
            check("mem_req_valid_hold", {31'd0, mem_req_valid}, 32'd1);
            check("mem_req_addr", mem_req_addr, exp_addr);
            check("mem_req_wen", {31'd0, mem_req_wen}, {31'd0, exp_wen});
            if (exp_wen) begin
                check("mem_req_wmask", {28'd0, mem_req_wmask}, {28'd0, exp_mask});
                check("mem_req_wdata", mem_req_wdata, exp_wdata);
            end
            if (i < hold) tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("mem_req_valid_drop", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0;
    endtask

    // Wait for a write-back beat, compare with the scoreboard head, optionally
    // stall the WBU for `hold` cycles checking stability, then accept it.
    task automatic collect(input int hold);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("out_valid_arrives", {31'd0, out_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            for (int i = 0; i <= hold; i++) begin
                check("out_valid_hold", {31'd0, out_valid}, 32'd1);
                if (e.chk_data) check("out_data", out_data, e.data);
                check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                check("out_reg_wen", {31'd0, out_reg_wen}, {31'd0, e.reg_wen});
                check("out_err", {31'd0, out_err}, {31'd0, e.err});
                check("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (i < hold) tick();
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_addr = 32'd0; in_wdata = 32'd0; in_ren = 1'b0; in_wen = 1'b0;
        in_funct3 = 3'd0; in_rd = 5'd0; in_reg_wen = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0; out_ready = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_out_reg_wen", {31'd0, out_reg_wen}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_mem_req_addr", mem_req_addr, 32'd0);
        check("rst_mem_req_wdata", mem_req_wdata, 32'd0);
        check("rst_mem_req_wmask", {28'd0, mem_req_wmask}, 32'd0);
        check("rst_mem_req_wen", {31'd0, mem_req_wen}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // passthrough: write-back one cycle after accept, no memory traffic
        push_exp(32'h12345678, 1'b1, 5'd5, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 32'h12345678, 32'd0, 5'd5, 1'b1);
        check("pass_out_valid_1cyc", {31'd0, out_valid}, 32'd1);
        check("pass_no_mem_req", {31'd0, mem_req_valid}, 32'd0);
        collect(0);

        // lb / lbu from the top byte lane
        push_exp(32'hFFFFFFAB, 1'b1, 5'd7, 1'b1, 1'b0);
        issue(1'b1, 1'b0, LB, 32'h80000003, 32'd0, 5'd7, 1'b1);
        serve_mem(32'h80000000, 1'b0, 4'd0, 32'd0, 32'hAB000000, 0);
        collect(0);

        push_exp(32'h000000AB, 1'b1, 5'd8, 1'b1, 1'b0);
        issue(1'b1, 1'b0, LBU, 32'h80000003, 32'd0, 5'd8, 1'b1);
        serve_mem(32'h80000000, 1'b0, 4'd0, 32'd0, 32'hAB000000, 0);
        collect(0);

        // lh / lhu from the upper halfword, lw aligned, rd=0 passed through
        push_exp(32'hFFFF8001, 1'b1, 5'd9, 1'b1, 1'b0);
        issue(1'b1, 1'b0, LH, 32'h80000002, 32'd0, 5'd9, 1'b1);
        serve_mem(32'h80000000, 1'b0, 4'd0, 32'd0, 32'h80011234, 0);
        collect(0);

        push_exp(32'h00008001, 1'b1, 5'd10, 1'b1, 1'b0);
        issue(1'b1, 1'b0, LHU, 32'h80000002, 32'd0, 5'd10, 1'b1);
        serve_mem(32'h80000000, 1'b0, 4'd0, 32'd0, 32'h80011234, 0);
        collect(0);

        push_exp(32'hDEADBEEF, 1'b1, 5'd0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, LW, 32'h80000004, 32'd0, 5'd0, 1'b1);
        serve_mem(32'h80000004, 1'b0, 4'd0, 32'd0, 32'hDEADBEEF, 0);
        collect(0);

        // sh with request backpressure of 5 cycles
        push_exp(32'd0, 1'b0, 5'd11, 1'b0, 1'b0);
        issue(1'b0, 1'b1, SH, 32'h80000002, 32'h0000BEEF, 5'd11, 1'b1);
        serve_mem(32'h80000000, 1'b1, 4'b1100, 32'hBEEF0000, 32'd0, 5);
        collect(0);

        // sb at lane 1 and sw
        push_exp(32'd0, 1'b0, 5'd12, 1'b0, 1'b0);
        issue(1'b0, 1'b1, SB, 32'h80000011, 32'h000000C3, 5'd12, 1'b1);
        serve_mem(32'h80000010, 1'b1, 4'b0010, 32'h0000C300, 32'd0, 0);
        collect(0);

        push_exp(32'd0, 1'b0, 5'd13, 1'b0, 1'b0);
        issue(1'b0, 1'b1, SW, 32'h80000020, 32'hCAFEF00D, 5'd13, 1'b1);
        serve_mem(32'h80000020, 1'b1, 4'b1111, 32'hCAFEF00D, 32'd0, 0);
        collect(0);

        // misaligned lw: no request, error reported next cycle
        push_exp(32'd0, 1'b1, 5'd14, 1'b0, 1'b1);
        issue(1'b1, 1'b0, LW, 32'h80000001, 32'd0, 5'd14, 1'b1);
        check("mis_lw_no_req", {31'd0, mem_req_valid}, 32'd0);
        check("mis_lw_out_valid", {31'd0, out_valid}, 32'd1);
        collect(0);

        // misaligned sh, illegal store funct3, load+store together
        push_exp(32'd0, 1'b1, 5'd15, 1'b0, 1'b1);
        issue(1'b0, 1'b1, SH, 32'h80000003, 32'h1234, 5'd15, 1'b1);
        check("mis_sh_no_req", {31'd0, mem_req_valid}, 32'd0);
        collect(0);

        push_exp(32'd0, 1'b1, 5'd16, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 3'b100, 32'h80000000, 32'h1234, 5'd16, 1'b1);
        check("ill_st_no_req", {31'd0, mem_req_valid}, 32'd0);
        collect(0);

        push_exp(32'd0, 1'b1, 5'd17, 1'b0, 1'b1);
        issue(1'b1, 1'b1, LW, 32'h80000000, 32'd0, 5'd17, 1'b1);
        check("ren_wen_no_req", {31'd0, mem_req_valid}, 32'd0);
        collect(0);

        // write-back backpressure while a new op waits at the input
        push_exp(32'h0BADF00D, 1'b1, 5'd18, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 32'h0BADF00D, 32'd0, 5'd18, 1'b1);
        in_valid = 1'b1; in_addr = 32'h55555555; in_rd = 5'd19; in_reg_wen = 1'b1;
        collect(4);
        in_valid = 1'b0;
        check("no_accept_during_done", {31'd0, out_valid}, 32'd0);

        // reset in WAIT abandons the transaction; stray response ignored
        issue(1'b1, 1'b0, LW, 32'h80000040, 32'd0, 5'd20, 1'b1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_wait_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wait_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hFFFFFFFF;
        tick();
        mem_resp_valid = 1'b0;
        check("stray_resp_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("stray_resp_out_valid2", {31'd0, out_valid}, 32'd0);
        check("stray_resp_in_ready", {31'd0, in_ready}, 32'd1);

        // recovery after reset
        push_exp(32'h00C0FFEE, 1'b1, 5'd21, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 32'h00C0FFEE, 32'd0, 5'd21, 1'b0);
        collect(0);

        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
